// File: rtl/check_skid.sv
// check_skid: bundle skid FIFO that decodes immediate, CSR and legal-format flags for each lane at the head
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   FLUSH             synchronous flush; empties the FIFO at the next edge
//   STALL, MMU_WAIT   hold the head and block pops; pushes still proceed
//   IN_VALID/IN_READY upstream handshake for one whole bundle
//   PC, OPCODE, RD, RS1, RS2, RINST   upstream bundle, lane i at slice i
//   CHECK_*           head bundle, or a NOP bundle when the FIFO is empty
//   REJECT_CNT        saturating count of popped bundles with any illegal lane
module check_skid #(
   parameter int COP_NUMS = 1,
   parameter int PNUMS    = COP_NUMS + 1,
   parameter int DEPTH    = 2,
   parameter bit IMM_SEXT = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  FLUSH,
   input  logic                  STALL,
   input  logic                  MMU_WAIT,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   input  logic [32*PNUMS-1:0]   PC,
   input  logic [17*PNUMS-1:0]   OPCODE,
   input  logic [5*PNUMS-1:0]    RD,
   input  logic [5*PNUMS-1:0]    RS1,
   input  logic [5*PNUMS-1:0]    RS2,
   input  logic [32*PNUMS-1:0]   RINST,
   output logic                  CHECK_VALID,
   output logic [PNUMS-1:0]      CHECK_ACCEPT,
   output logic [32*PNUMS-1:0]   CHECK_PC,
   output logic [17*PNUMS-1:0]   CHECK_OPCODE,
   output logic [5*PNUMS-1:0]    CHECK_RD,
   output logic [5*PNUMS-1:0]    CHECK_RS1,
   output logic [5*PNUMS-1:0]    CHECK_RS2,
   output logic [12*PNUMS-1:0]   CHECK_CSR,
   output logic [32*PNUMS-1:0]   CHECK_IMM,
   output logic [15:0]           REJECT_CNT
);
   localparam int AW = $clog2(DEPTH);
   localparam int W  = 96 * PNUMS;
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
   logic [W-1:0]    mem_q [DEPTH];
   logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [15:0]     rej_q, rej_d;
   logic            push, pop;
   logic [W-1:0]    head;
   logic [32*PNUMS-1:0] rinst;
   assign IN_READY    = cnt_q < FULL;
   assign CHECK_VALID = cnt_q != '0;
   assign REJECT_CNT  = rej_q;
   assign push = IN_VALID & IN_READY & ~FLUSH;
   assign pop  = CHECK_VALID & ~STALL & ~MMU_WAIT & ~FLUSH;
   // An empty FIFO presents all-zero fields with an addi x0,x0,0 in every lane
   assign head = CHECK_VALID ? mem_q[rd_q] : {{(64 * PNUMS){1'b0}}, {PNUMS{32'h0000_0013}}};
   assign {CHECK_PC, CHECK_OPCODE, CHECK_RD, CHECK_RS1, CHECK_RS2, rinst} = head;
   always_comb begin
      wr_d  = FLUSH ? '0 : wr_q + AW'(push);
      rd_d  = FLUSH ? '0 : rd_q + AW'(pop);
      cnt_d = FLUSH ? '0 : cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
      rej_d = (pop & ~&CHECK_ACCEPT & ~&rej_q) ? rej_q + 16'd1 : rej_q;
   end
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         rej_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         rej_q <= rej_d;
      end
   end
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_q] <= {PC, OPCODE, RD, RS1, RS2, RINST};
   end
   for (genvar i = 0; i < PNUMS; i++) begin : g_lane
      logic [31:0] r;
      logic [6:0]  op;
      logic        s, is_r, is_i, is_s, is_b, is_u, is_j;
      assign r    = rinst[32*i +: 32];
      assign op   = r[6:0];
      assign s    = IMM_SEXT && r[31];
      assign is_r = op == 7'b0110011;
      assign is_i = op inside {7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011};
      assign is_s = op == 7'b0100011;
      assign is_b = op == 7'b1100011;
      assign is_u = op inside {7'b0110111, 7'b0010111};
      assign is_j = op == 7'b1101111;
      // Legality comes from the opcode class, never from the immediate value
      assign CHECK_ACCEPT[i]       = is_r | is_i | is_s | is_b | is_u | is_j;
      assign CHECK_CSR[12*i +: 12] = r[31:20];
      assign CHECK_IMM[32*i +: 32] = is_r ? 32'd0 :
                                     is_i ? {{20{s}}, r[31:20]} :
                                     is_s ? {{20{s}}, r[31:25], r[11:7]} :
                                     is_b ? {{19{s}}, r[31], r[7], r[30:25], r[11:8], 1'b0} :
                                     is_u ? {r[31:12], 12'd0} :
                                     is_j ? {{11{s}}, r[31], r[19:12], r[20], r[30:21], 1'b0} :
                                            32'hFFFF_FFFF;
   end
endmodule

// File: tb/tb_check_skid.sv
// tb_check_skid: directed bench comparing two check_skid instances (zero- and sign-extending) against a queue model
module tb_check_skid;
   localparam int P = 2;
   localparam int D = 2;
   logic CLK = 1'b0, RST_N = 1'b0, FLUSH = 1'b0, STALL = 1'b0, MMU_WAIT = 1'b0, IN_VALID = 1'b0;
   logic [32*P-1:0] PC = '0, RINST = '0;
   logic [17*P-1:0] OPCODE = '0;
   logic [5*P-1:0]  RD = '0, RS1 = '0, RS2 = '0;
   logic            rdy [2];
   logic            vld [2];
   logic [P-1:0]    acc [2];
   logic [32*P-1:0] cpc [2];
   logic [17*P-1:0] cop [2];
   logic [5*P-1:0]  crd [2];
   logic [5*P-1:0]  crs1 [2];
   logic [5*P-1:0]  crs2 [2];
   logic [12*P-1:0] csr [2];
   logic [32*P-1:0] imm [2];
   logic [15:0]     rej [2];
   int n_chk = 0;
   int n_fail = 0;
   typedef struct packed {
      logic [32*P-1:0] pc;
      logic [17*P-1:0] op;
      logic [5*P-1:0]  rd, rs1, rs2;
      logic [32*P-1:0] ri;
   } bundle_t;
   bundle_t q[$];
   int      m_rej = 0;
   always #5 CLK = ~CLK;
   check_skid #(.COP_NUMS(1), .DEPTH(D), .IMM_SEXT(1'b0)) u0 (
      .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .STALL(STALL), .MMU_WAIT(MMU_WAIT),
      .IN_VALID(IN_VALID), .IN_READY(rdy[0]), .PC(PC), .OPCODE(OPCODE), .RD(RD), .RS1(RS1),
      .RS2(RS2), .RINST(RINST), .CHECK_VALID(vld[0]), .CHECK_ACCEPT(acc[0]), .CHECK_PC(cpc[0]),
      .CHECK_OPCODE(cop[0]), .CHECK_RD(crd[0]), .CHECK_RS1(crs1[0]), .CHECK_RS2(crs2[0]),
      .CHECK_CSR(csr[0]), .CHECK_IMM(imm[0]), .REJECT_CNT(rej[0]));
   check_skid #(.COP_NUMS(1), .DEPTH(D), .IMM_SEXT(1'b1)) u1 (
      .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .STALL(STALL), .MMU_WAIT(MMU_WAIT),
      .IN_VALID(IN_VALID), .IN_READY(rdy[1]), .PC(PC), .OPCODE(OPCODE), .RD(RD), .RS1(RS1),
      .RS2(RS2), .RINST(RINST), .CHECK_VALID(vld[1]), .CHECK_ACCEPT(acc[1]), .CHECK_PC(cpc[1]),
      .CHECK_OPCODE(cop[1]), .CHECK_RD(crd[1]), .CHECK_RS1(crs1[1]), .CHECK_RS2(crs2[1]),
      .CHECK_CSR(csr[1]), .CHECK_IMM(imm[1]), .REJECT_CNT(rej[1]));
   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask
   function automatic bit legal(input logic [31:0] r);
      return r[6:0] inside {7'b0110011, 7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111,
                            7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
   endfunction
   // Immediate from the field layout and its width, then extended by arithmetic on the width
   function automatic logic [31:0] imm_of(input logic [31:0] r, input bit sx);
      logic [31:0] f;
      int w;
      f = '0;
      w = 32;
      case (r[6:0])
         7'b0110011: return 32'd0;
         7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin f = 32'(r[31:20]); w = 12; end
         7'b0100011: begin f = 32'({r[31:25], r[11:7]}); w = 12; end
         7'b1100011: begin f = 32'({r[31], r[7], r[30:25], r[11:8], 1'b0}); w = 13; end
         7'b0110111, 7'b0010111: return r & 32'hFFFF_F000;
         7'b1101111: begin f = 32'({r[31], r[19:12], r[20], r[30:21], 1'b0}); w = 21; end
         default: return 32'hFFFF_FFFF;
      endcase
      if (sx && f[w-1]) f = f | (32'hFFFF_FFFF << w);
      return f;
   endfunction
   function automatic bundle_t head_of();
      bundle_t n;
      n = '0;
      n.ri = {P{32'h0000_0013}};
      return q.size() != 0 ? q[0] : n;
   endfunction
   function automatic logic [P-1:0] acc_of(input bundle_t b);
      logic [P-1:0] a;
      for (int l = 0; l < P; l++) a[l] = legal(b.ri[32*l +: 32]);
      return a;
   endfunction
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q.delete();
         m_rej = 0;
      end else begin
         bit pu, po;
         pu = IN_VALID && q.size() < D && !FLUSH;
         po = q.size() != 0 && !STALL && !MMU_WAIT && !FLUSH;
         if (FLUSH) q.delete();
         else begin
            if (po) begin
               if (acc_of(q[0]) != {P{1'b1}} && m_rej < 65535) m_rej = m_rej + 1;
               void'(q.pop_front());
            end
            if (pu) q.push_back('{pc: PC, op: OPCODE, rd: RD, rs1: RS1, rs2: RS2, ri: RINST});
         end
      end
   end
   always @(negedge CLK) begin
      if (RST_N) begin
         for (int k = 0; k < 2; k++) begin
            bundle_t h;
            logic [32*P-1:0] ei;
            logic [12*P-1:0] ec;
            h = head_of();
            for (int l = 0; l < P; l++) begin
               ei[32*l +: 32] = imm_of(h.ri[32*l +: 32], k == 1);
               ec[12*l +: 12] = h.ri[32*l+20 +: 12];
            end
            check("valid", 64'(vld[k]), 64'(q.size() != 0));
            check("ready", 64'(rdy[k]), 64'(q.size() < D));
            check("pc", 64'(cpc[k]), 64'(h.pc));
            check("opcode", 64'(cop[k]), 64'(h.op));
            check("rd", 64'(crd[k]), 64'(h.rd));
            check("rs1", 64'(crs1[k]), 64'(h.rs1));
            check("rs2", 64'(crs2[k]), 64'(h.rs2));
            check("csr", 64'(csr[k]), 64'(ec));
            check("imm", 64'(imm[k]), 64'(ei));
            check("accept", 64'(acc[k]), 64'(acc_of(h)));
            check("reject_cnt", 64'(rej[k]), 64'(m_rej));
         end
      end
   end
   task automatic step();
      @(posedge CLK);
      #1;
   endtask
   task automatic set_b(input logic [31:0] p, input logic [31:0] r0, input logic [31:0] r1);
      PC     = {p + 32'd4, p};
      OPCODE = {17'(p * 3), 17'(p)};
      RD     = {5'(p + 1), 5'(p)};
      RS1    = {5'(p + 2), 5'(p + 3)};
      RS2    = {5'(p + 5), 5'(p + 7)};
      RINST  = {r1, r0};
   endtask
   initial begin
      set_b(32'h0, 32'h13, 32'h13);
      repeat (2) step();
      check("lit_reset_valid", 64'(vld[0]), 64'd0);
      check("lit_reset_ready", 64'(rdy[0]), 64'd1);
      check("lit_reset_imm", 64'(imm[1]), 64'd0);
      check("lit_reset_accept", 64'(acc[0]), 64'h3);
      check("lit_reset_rej", 64'(rej[0]), 64'd0);
      RST_N = 1'b1;
      set_b(32'h100, 32'h00A0_0093, 32'h13);
      IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      check("lit_addi_valid", 64'(vld[0]), 64'd1);
      check("lit_addi_pc", 64'(cpc[0][31:0]), 64'h100);
      check("lit_addi_imm", 64'(imm[0][31:0]), 64'h00A);
      check("lit_addi_accept", 64'(acc[0][0]), 64'd1);
      set_b(32'h200, 32'hFFF0_0093, 32'h13);
      IN_VALID = 1'b1;
      step();
      IN_VALID = 1'b0;
      check("lit_sext_imm", 64'(imm[1][31:0]), 64'hFFFF_FFFF);
      check("lit_zext_imm", 64'(imm[0][31:0]), 64'h0000_0FFF);
      check("lit_sext_accept", 64'(acc[1][0]), 64'd1);
      step();
      STALL = 1'b1;
      IN_VALID = 1'b1;
      set_b(32'h1, 32'h13, 32'h13);
      step();
      set_b(32'h2, 32'hFE20_8EE3, 32'h0010_006F);
      step();
      check("lit_full_ready", 64'(rdy[0]), 64'd0);
      set_b(32'h3, 32'h1234_50B7, 32'hFE11_2E23);
      step();
      step();
      check("lit_stall_head", 64'(cpc[0][31:0]), 64'h1);
      STALL = 1'b0;
      step();
      check("lit_order_2", 64'(cpc[0][31:0]), 64'h2);
      step();
      check("lit_order_3", 64'(cpc[0][31:0]), 64'h3);
      IN_VALID = 1'b0;
      step();
      check("lit_drained", 64'(vld[0]), 64'd0);
      RST_N = 1'b0;
      step();
      RST_N = 1'b1;
      set_b(32'h300, 32'h13, 32'h7F);
      IN_VALID = 1'b1;
      step();
      check("lit_bad_accept", 64'(acc[1]), 64'h1);
      check("lit_bad_imm", 64'(imm[0][63:32]), 64'hFFFF_FFFF);
      step();
      step();
      IN_VALID = 1'b0;
      step();
      check("lit_rej3", 64'(rej[0]), 64'd3);
      STALL = 1'b1;
      set_b(32'h400, 32'h13, 32'h13);
      IN_VALID = 1'b1;
      step();
      step();
      FLUSH = 1'b1;
      step();
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      STALL = 1'b0;
      check("lit_flush_valid", 64'(vld[0]), 64'd0);
      check("lit_flush_pc", 64'(cpc[0]), 64'd0);
      check("lit_flush_ready", 64'(rdy[0]), 64'd1);
      check("lit_flush_rej", 64'(rej[1]), 64'd3);
      STALL = 1'b1;
      IN_VALID = 1'b1;
      step();
      step();
      IN_VALID = 1'b0;
      #1 RST_N = 1'b0;
      #1 check("lit_async_reset", 64'(vld[0]), 64'd0);
      #1 RST_N = 1'b1;
      STALL = 1'b0;
      step();
      set_b(32'h500, 32'h13, 32'h7F);
      IN_VALID = 1'b1;
      repeat (65540) step();
      check("lit_rej_sat", 64'(rej[0]), 64'hFFFF);
      IN_VALID = 1'b0;
      repeat (3) step();
      check("lit_rej_hold", 64'(rej[1]), 64'hFFFF);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
